macro_seq_layer4: RTL and testbench
===================================

// Module: macro_seq_layer4
// PURPOSE
//  Per-pixel timing sequencer for the layer-4 CIM macro array. Each accepted data_e strobe
//  (one RSign'd pixel) runs one macro cycle: latch pulse, settle wait, ADC window, then a
//  one-cycle mc_data_e to the decoder/partial-sum path. Tracks pixel row/col in the frame and
//  emits vs_next after the frame's last pixel. Flags pixels arriving while the macro is busy.
// PARAMETERS
//  FM_WIDTH    56  feature-map width = height (square map), pixels per row/rows per frame
//  LATCH_CYC   1   cycles latch held high (>=1)
//  SETTLE_CYC  2   cycles between latch fall and adc rise (>=0)
//  ADC_CYC     3   cycles adc held high (>=1)
//  CNT_W       $clog2(FM_WIDTH)  row/col counter width (derived, localparam)
// PORTS
//  clk         in   1      system clock
//  rstn        in   1      asynchronous active-low reset
//  mode_in     in   1      0 = parameter reload (sequencer held idle), 1 = calculate
//  vs          in   1      frame-start pulse, one cycle
//  data_e      in   1      pixel valid strobe from RSign path
//  latch       out  1      macro input latch enable
//  adc         out  1      macro ADC conversion enable
//  mc_data_e   out  1      one-cycle pulse: macro outputs valid for decoder
//  busy        out  1      high in any state except IDLE
//  col_idx     out  CNT_W  column of pixel currently/last in flight
//  row_idx     out  CNT_W  row of pixel currently/last in flight
//  vs_next     out  1      one-cycle frame-done pulse to next layer
//  overrun_err out  1      sticky: data_e dropped because sequencer busy
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; counters 0. All outputs registered.
//  FSM IDLE -> LATCH -> SETTLE -> CONVERT -> OUTPUT -> IDLE (SETTLE skipped if SETTLE_CYC=0).
//   IDLE: data_e & mode_in -> LATCH.  LATCH: latch=1 for LATCH_CYC cycles.
//   SETTLE: all low SETTLE_CYC cycles.  CONVERT: adc=1 for ADC_CYC cycles.
//   OUTPUT: mc_data_e=1 one cycle; if data_e this cycle -> LATCH (back-to-back), else IDLE.
//  Latency: data_e at cycle t -> latch t+1.., mc_data_e at t+1+LATCH_CYC+SETTLE_CYC+ADC_CYC
//   (defaults: t+7). Min accepted pixel period = LATCH_CYC+SETTLE_CYC+ADC_CYC+1 (7).
//  data_e in LATCH/SETTLE/CONVERT: pixel dropped, overrun_err<=1 (sticky until vs or reset).
//  Counters advance on mc_data_e: col++ ; col==FM_WIDTH-1 -> col=0,row++.
//   Last pixel (row=col=FM_WIDTH-1): vs_next=1 same cycle as mc_data_e; row,col wrap to 0.
//  vs (mode_in=1): abort any in-flight pixel (no mc_data_e), state->IDLE, row/col=0,
//   overrun_err=0. vs & data_e same cycle: data_e accepted as pixel (0,0) -> LATCH.
//  mode_in=0: synchronous return to IDLE next cycle, latch/adc/mc_data_e/vs_next forced 0,
//   counters and overrun_err cleared; data_e ignored.
//  Reset mid-operation: immediate async return to reset values, no pulses emitted.
//  Internal phase counter width $clog2(max(LATCH_CYC,SETTLE_CYC,ADC_CYC)+1); reloads per state.
// TESTING (FM_WIDTH=3, defaults otherwise)
//  Single pixel: vs@0, data_e@1 -> latch@2, adc@5-7, mc_data_e@8, busy 2..8, col_idx->1.
//  Back-to-back: data_e every 7 cycles x9 -> 9 mc_data_e, no overrun_err, vs_next with 9th.
//  Overrun: data_e@1 and @4 -> one mc_data_e@8, overrun_err=1 from @5; next vs clears it.
//  Abort: data_e@1, vs@4 -> no mc_data_e, latch/adc low from @5, counters 0, idle @5.
//  Mode: mode_in=0 @3 mid-pixel -> idle @4, outputs 0; data_e while mode_in=0 ignored.
//  Reset: rstn low during CONVERT -> adc=0, busy=0 immediately; counters 0.

Source files
------------

// File: rtl/macro_seq_layer4_if.sv
// -----------------------------------------------------------------------------
// macro_seq_layer4_if
// Bundles the pixel-strobe inputs and the macro timing outputs of the layer-4
// CIM sequencer.
//   master : drives mode_in / vs / data_e, observes the timing outputs
//   slave  : the sequencer itself
//   mode_in     0 = parameter reload, 1 = calculate
//   vs          frame-start pulse
//   data_e      pixel valid strobe
//   latch/adc   macro latch and ADC enables
//   mc_data_e   one-cycle "macro outputs valid" pulse
//   busy        sequencer not idle
//   col_idx/row_idx  position of the pixel in flight / last processed
//   vs_next     frame-done pulse to the next layer
//   overrun_err sticky dropped-pixel flag
// -----------------------------------------------------------------------------
interface macro_seq_layer4_if #(
  parameter int CNT_W = 6
);
  logic             mode_in;
  logic             vs;
  logic             data_e;
  logic             latch;
  logic             adc;
  logic             mc_data_e;
  logic             busy;
  logic [CNT_W-1:0] col_idx;
  logic [CNT_W-1:0] row_idx;
  logic             vs_next;
  logic             overrun_err;

  modport master (
    output mode_in, vs, data_e,
    input  latch, adc, mc_data_e, busy, col_idx, row_idx, vs_next, overrun_err
  );

  modport slave (
    input  mode_in, vs, data_e,
    output latch, adc, mc_data_e, busy, col_idx, row_idx, vs_next, overrun_err
  );
endinterface

// File: rtl/macro_seq_layer4.sv
// -----------------------------------------------------------------------------
// macro_seq_layer4
// Per-pixel timing sequencer for the layer-4 CIM macro array. Every accepted
// data_e runs one macro cycle (latch, settle, ADC window, output pulse), tracks
// the pixel's row/col in a square frame and pulses vs_next after the last
// pixel. Pixels arriving while the macro is mid-cycle are dropped and flagged.
// Ports:
//   clk   system clock
//   rstn  asynchronous active-low reset
//   bus   macro_seq_layer4_if.slave (strobes in, registered timing outputs)
// -----------------------------------------------------------------------------
module macro_seq_layer4 #(
  parameter int FM_WIDTH   = 56,
  parameter int LATCH_CYC  = 1,
  parameter int SETTLE_CYC = 2,
  parameter int ADC_CYC    = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  macro_seq_layer4_if.slave     bus
);

  localparam int CNT_W   = $clog2(FM_WIDTH);
  localparam int MAX_LS  = (LATCH_CYC > SETTLE_CYC) ? LATCH_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_LS > ADC_CYC) ? MAX_LS : ADC_CYC;
  localparam int PH_W    = $clog2(MAX_CYC + 1);

  // Phase counter counts down from (cycles-1) to zero inside each timed state.
  localparam logic [PH_W-1:0]  LATCH_LD  = PH_W'(LATCH_CYC - 1);
  localparam logic [PH_W-1:0]  SETTLE_LD = PH_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  localparam logic [PH_W-1:0]  ADC_LD    = PH_W'(ADC_CYC - 1);
  localparam logic [PH_W-1:0]  PH_ZERO   = {PH_W{1'b0}};
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(FM_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LATCH   = 3'd1,
    SETTLE  = 3'd2,
    CONVERT = 3'd3,
    OUTPUT  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] row_q, row_d;
  logic             ovr_q, ovr_d;

  logic latch_q, adc_q, mc_q, busy_q, vs_next_q;

  // Next-state, phase, position counter and overrun flag computation.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    row_d   = row_q;
    ovr_d   = ovr_q;

    if (!bus.mode_in) begin
      // Parameter reload: sequencer parked, everything cleared, strobes ignored.
      state_d = IDLE;
      phase_d = PH_ZERO;
      col_d   = CNT_ZERO;
      row_d   = CNT_ZERO;
      ovr_d   = 1'b0;
    end else if (bus.vs) begin
      // Frame start aborts any pixel in flight; a coincident strobe is pixel (0,0).
      col_d = CNT_ZERO;
      row_d = CNT_ZERO;
      ovr_d = 1'b0;
      if (bus.data_e) begin
        state_d = LATCH;
        phase_d = LATCH_LD;
      end else begin
        state_d = IDLE;
        phase_d = PH_ZERO;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.data_e) begin
            state_d = LATCH;
            phase_d = LATCH_LD;
          end else begin
            state_d = IDLE;
          end
        end
        LATCH: begin
          if (bus.data_e) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
          if (phase_q != PH_ZERO) begin
            phase_d = phase_q - PH_W'(1);
          end else if (SETTLE_CYC > 0) begin
            state_d = SETTLE;
            phase_d = SETTLE_LD;
          end else begin
            state_d = CONVERT;
            phase_d = ADC_LD;
          end
        end
        SETTLE: begin
          if (bus.data_e) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
          if (phase_q != PH_ZERO) begin
            phase_d = phase_q - PH_W'(1);
          end else begin
            state_d = CONVERT;
            phase_d = ADC_LD;
          end
        end
        CONVERT: begin
          if (bus.data_e) begin
            ovr_d = 1'b1;
          end else begin
            ovr_d = ovr_q;
          end
          if (phase_q != PH_ZERO) begin
            phase_d = phase_q - PH_W'(1);
          end else begin
            state_d = OUTPUT;
            phase_d = PH_ZERO;
          end
        end
        OUTPUT: begin
          // Position advances once the pixel's output pulse has been seen.
          if (col_q == LAST) begin
            col_d = CNT_ZERO;
            if (row_q == LAST) begin
              row_d = CNT_ZERO;
            end else begin
              row_d = row_q + CNT_W'(1);
            end
          end else begin
            col_d = col_q + CNT_W'(1);
          end
          if (bus.data_e) begin
            state_d = LATCH;
            phase_d = LATCH_LD;
          end else begin
            state_d = IDLE;
            phase_d = PH_ZERO;
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = PH_ZERO;
        end
      endcase
    end
  end

  // State, phase, counters and sticky flag registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      phase_q <= PH_ZERO;
      col_q   <= CNT_ZERO;
      row_q   <= CNT_ZERO;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ovr_q   <= ovr_d;
    end
  end

  // Registered timing outputs decoded from the upcoming state so they align with it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      latch_q   <= 1'b0;
      adc_q     <= 1'b0;
      mc_q      <= 1'b0;
      busy_q    <= 1'b0;
      vs_next_q <= 1'b0;
    end else begin
      latch_q   <= (state_d == LATCH);
      adc_q     <= (state_d == CONVERT);
      mc_q      <= (state_d == OUTPUT);
      busy_q    <= (state_d != IDLE);
      // Entry into OUTPUT only happens from CONVERT, so row/col still name this pixel.
      vs_next_q <= (state_d == OUTPUT) && (row_q == LAST) && (col_q == LAST);
    end
  end

  assign bus.latch       = latch_q;
  assign bus.adc         = adc_q;
  assign bus.mc_data_e   = mc_q;
  assign bus.busy        = busy_q;
  assign bus.col_idx     = col_q;
  assign bus.row_idx     = row_q;
  assign bus.vs_next     = vs_next_q;
  assign bus.overrun_err = ovr_q;

endmodule

// File: tb/tb_macro_seq_layer4.sv
// -----------------------------------------------------------------------------
// tb_macro_seq_layer4
// Directed bench for macro_seq_layer4 with FM_WIDTH=3 and default timing.
// Inputs are driven #1 after a rising edge and apply to that cycle; outputs
// are sampled at the same point and belong to the cycle just started.
// -----------------------------------------------------------------------------
module tb_macro_seq_layer4;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  macro_seq_layer4_if #(.CNT_W(2)) bus ();

  macro_seq_layer4 #(
    .FM_WIDTH  (3),
    .LATCH_CYC (1),
    .SETTLE_CYC(2),
    .ADC_CYC   (3)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rstn        = 1'b0;
    bus.mode_in = 1'b1;
    bus.vs      = 1'b0;
    bus.data_e  = 1'b0;

    // ---- reset state ----
    tick();
    tick();
    chk1("rst_latch", bus.latch, 1'b0);
    chk1("rst_adc", bus.adc, 1'b0);
    chk1("rst_mc", bus.mc_data_e, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_vsn", bus.vs_next, 1'b0);
    chk1("rst_ovr", bus.overrun_err, 1'b0);
    chkn("rst_col", 8'(bus.col_idx), 8'd0);
    chkn("rst_row", 8'(bus.row_idx), 8'd0);
    rstn = 1'b1;
    tick();

    // ---- single pixel: vs@0, data_e@1 ----
    bus.vs = 1'b1;                     // cycle 0
    tick();
    bus.vs = 1'b0; bus.data_e = 1'b1;  // cycle 1
    tick();                            // cycle 2
    bus.data_e = 1'b0;
    chk1("sp_latch2", bus.latch, 1'b1);
    chk1("sp_busy2", bus.busy, 1'b1);
    chk1("sp_adc2", bus.adc, 1'b0);
    tick();                            // cycle 3
    chk1("sp_latch3", bus.latch, 1'b0);
    chk1("sp_busy3", bus.busy, 1'b1);
    tick();                            // cycle 4
    chk1("sp_adc4", bus.adc, 1'b0);
    tick();                            // cycle 5
    chk1("sp_adc5", bus.adc, 1'b1);
    tick();                            // cycle 6
    chk1("sp_adc6", bus.adc, 1'b1);
    tick();                            // cycle 7
    chk1("sp_adc7", bus.adc, 1'b1);
    chk1("sp_mc7", bus.mc_data_e, 1'b0);
    tick();                            // cycle 8
    chk1("sp_mc8", bus.mc_data_e, 1'b1);
    chk1("sp_adc8", bus.adc, 1'b0);
    chk1("sp_busy8", bus.busy, 1'b1);
    chk1("sp_vsn8", bus.vs_next, 1'b0);
    tick();                            // cycle 9
    chk1("sp_mc9", bus.mc_data_e, 1'b0);
    chk1("sp_busy9", bus.busy, 1'b0);
    chkn("sp_col9", 8'(bus.col_idx), 8'd1);
    chkn("sp_row9", 8'(bus.row_idx), 8'd0);

    // ---- back-to-back: 9 pixels, period 7, frame done on the 9th ----
    bus.vs = 1'b1;
    tick();
    bus.vs = 1'b0;
    chkn("bb_col_clr", 8'(bus.col_idx), 8'd0);
    bus.data_e = 1'b1;
    tick();                            // first LATCH cycle
    bus.data_e = 1'b0;
    for (int p = 0; p < 9; p++) begin
      for (int k = 0; k < 6; k++) tick();
      chk1("bb_mc", bus.mc_data_e, 1'b1);
      chk1("bb_vsn", bus.vs_next, (p == 8) ? 1'b1 : 1'b0);
      chkn("bb_col", 8'(bus.col_idx), 8'(p % 3));
      chkn("bb_row", 8'(bus.row_idx), 8'(p / 3));
      chk1("bb_ovr", bus.overrun_err, 1'b0);
      if (p < 8) begin
        bus.data_e = 1'b1;             // next pixel strobed in the OUTPUT cycle
        tick();
        bus.data_e = 1'b0;
        chk1("bb_relatch", bus.latch, 1'b1);
      end else begin
        tick();
      end
    end
    chk1("bb_end_mc", bus.mc_data_e, 1'b0);
    chk1("bb_end_vsn", bus.vs_next, 1'b0);
    chk1("bb_end_busy", bus.busy, 1'b0);
    chkn("bb_end_col", 8'(bus.col_idx), 8'd0);
    chkn("bb_end_row", 8'(bus.row_idx), 8'd0);

    // ---- overrun: data_e@1 and @4 ----
    bus.vs = 1'b1;                     // cycle 0
    tick();
    bus.vs = 1'b0; bus.data_e = 1'b1;  // cycle 1
    tick();
    bus.data_e = 1'b0;                 // cycle 2
    tick();                            // cycle 3
    tick();                            // cycle 4
    chk1("ov_ovr4", bus.overrun_err, 1'b0);
    bus.data_e = 1'b1;
    tick();                            // cycle 5
    bus.data_e = 1'b0;
    chk1("ov_ovr5", bus.overrun_err, 1'b1);
    chk1("ov_adc5", bus.adc, 1'b1);
    tick();
    tick();
    tick();                            // cycle 8
    chk1("ov_mc8", bus.mc_data_e, 1'b1);
    chk1("ov_ovr8", bus.overrun_err, 1'b1);
    tick();                            // cycle 9
    chk1("ov_busy9", bus.busy, 1'b0);
    chk1("ov_latch9", bus.latch, 1'b0);
    chkn("ov_col9", 8'(bus.col_idx), 8'd1);
    bus.vs = 1'b1;
    tick();
    bus.vs = 1'b0;
    chk1("ov_clr", bus.overrun_err, 1'b0);
    chkn("ov_col_clr", 8'(bus.col_idx), 8'd0);

    // ---- abort: complete one pixel so col=1, then vs cancels the next ----
    bus.data_e = 1'b1;
    tick();
    bus.data_e = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chkn("ab_col_pre", 8'(bus.col_idx), 8'd1);
    bus.data_e = 1'b1;                 // cycle 1
    tick();
    bus.data_e = 1'b0;                 // cycle 2
    tick();                            // cycle 3
    tick();                            // cycle 4
    bus.vs = 1'b1;
    tick();                            // cycle 5
    bus.vs = 1'b0;
    chk1("ab_busy5", bus.busy, 1'b0);
    chk1("ab_latch5", bus.latch, 1'b0);
    chk1("ab_adc5", bus.adc, 1'b0);
    chkn("ab_col5", 8'(bus.col_idx), 8'd0);
    chkn("ab_row5", 8'(bus.row_idx), 8'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("ab_no_mc", bus.mc_data_e, 1'b0);
      chk1("ab_no_adc", bus.adc, 1'b0);
    end

    // ---- vs & data_e together, overrun, then mode_in=0 mid-pixel ----
    bus.vs = 1'b1; bus.data_e = 1'b1;  // cycle 1
    tick();                            // cycle 2
    bus.vs = 1'b0;                     // data_e held: dropped during LATCH
    chk1("md_latch2", bus.latch, 1'b1);
    chkn("md_col2", 8'(bus.col_idx), 8'd0);
    tick();                            // cycle 3
    bus.data_e = 1'b0;
    chk1("md_ovr3", bus.overrun_err, 1'b1);
    chk1("md_busy3", bus.busy, 1'b1);
    bus.mode_in = 1'b0;
    tick();                            // cycle 4
    chk1("md_busy4", bus.busy, 1'b0);
    chk1("md_latch4", bus.latch, 1'b0);
    chk1("md_adc4", bus.adc, 1'b0);
    chk1("md_ovr4", bus.overrun_err, 1'b0);
    bus.data_e = 1'b1;
    tick();
    bus.data_e = 1'b0;
    chk1("md_ign_busy", bus.busy, 1'b0);
    chk1("md_ign_latch", bus.latch, 1'b0);
    tick();
    chk1("md_ign_busy2", bus.busy, 1'b0);
    bus.mode_in = 1'b1;
    tick();

    // ---- async reset during CONVERT ----
    bus.data_e = 1'b1;
    tick();
    bus.data_e = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    chkn("rs_col_pre", 8'(bus.col_idx), 8'd1);
    bus.data_e = 1'b1;                 // cycle 1
    tick();
    bus.data_e = 1'b0;
    tick();
    tick();
    tick();                            // cycle 5: CONVERT
    chk1("rs_adc_pre", bus.adc, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("rs_adc", bus.adc, 1'b0);
    chk1("rs_busy", bus.busy, 1'b0);
    chkn("rs_col", 8'(bus.col_idx), 8'd0);
    chkn("rs_row", 8'(bus.row_idx), 8'd0);
    tick();
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk1("rs_no_mc", bus.mc_data_e, 1'b0);
      chk1("rs_idle", bus.busy, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
